// File: rtl/fpu_issue_wb_if.sv
// Decode/FPU/writeback bundle for the FP issue and writeback controller.
//
// Purpose: carries every non-clock signal between decode, the fixed-latency
// FPU datapath, the register file / SR write port and fpu_issue_wb.
//
// Port summary (direction as seen by fpu_issue_wb, modport "slave"):
//   in : dcValid, dcOpMode[7:0], dcIdMode[1:0], dcRegA/B/C[6:0], dcWrSr,
//        flush, fpuIdRegD[6:0], fpuIdModeD[1:0], fpuValD[63:0],
//        fpuOutSr[31:0]
//   out: dcReady, fpuOpMode[7:0], fpuIdMode[1:0], fpuRegA/B/C[6:0],
//        wbEn, wbReg[6:0], wbMode[1:0], wbVal[63:0], wbHiEn,
//        srWrEn, srT, busy
// The "master" modport is the mirror image (decode + FPU + register file).
//
// Handshake: an op transfers from decode in a cycle where dcValid and
// dcReady are both high and flush is low. While dcValid is high and dcReady
// is low, decode holds every dc* field (and the FPU holds fpuIdRegD /
// fpuIdModeD) stable; dcReady never depends on a transfer completing.
interface fpu_issue_wb_if;
  // decode side
  logic        dcValid;
  logic        dcReady;
  logic [7:0]  dcOpMode;
  logic [1:0]  dcIdMode;
  logic [6:0]  dcRegA;
  logic [6:0]  dcRegB;
  logic [6:0]  dcRegC;
  logic        dcWrSr;
  logic        flush;
  // FPU datapath side
  logic [7:0]  fpuOpMode;
  logic [1:0]  fpuIdMode;
  logic [6:0]  fpuRegA;
  logic [6:0]  fpuRegB;
  logic [6:0]  fpuRegC;
  logic [6:0]  fpuIdRegD;
  logic [1:0]  fpuIdModeD;
  logic [63:0] fpuValD;
  logic [31:0] fpuOutSr;
  // register file / SR write side
  logic        wbEn;
  logic [6:0]  wbReg;
  logic [1:0]  wbMode;
  logic [63:0] wbVal;
  logic        wbHiEn;
  logic        srWrEn;
  logic        srT;
  logic        busy;

  modport slave (
    input  dcValid, dcOpMode, dcIdMode, dcRegA, dcRegB, dcRegC, dcWrSr, flush,
    input  fpuIdRegD, fpuIdModeD, fpuValD, fpuOutSr,
    output dcReady, fpuOpMode, fpuIdMode, fpuRegA, fpuRegB, fpuRegC,
    output wbEn, wbReg, wbMode, wbVal, wbHiEn, srWrEn, srT, busy
  );

  modport master (
    output dcValid, dcOpMode, dcIdMode, dcRegA, dcRegB, dcRegC, dcWrSr, flush,
    output fpuIdRegD, fpuIdModeD, fpuValD, fpuOutSr,
    input  dcReady, fpuOpMode, fpuIdMode, fpuRegA, fpuRegB, fpuRegC,
    input  wbEn, wbReg, wbMode, wbVal, wbHiEn, srWrEn, srT, busy
  );
endinterface

// File: rtl/fpu_issue_wb.sv
// Issue and writeback controller for the fixed-latency FP pipeline.
//
// Purpose: accepts FPU micro-ops from decode, holds them back while any
// source register overlaps a destination still in flight, drives the FPU
// op/register inputs in the issue cycle, carries each op's destination tag
// down a LAT-deep shadow pipeline and, LAT cycles after issue, captures the
// FPU result (or SR.T) into a registered writeback stage.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active high; overrides flush and issue
//   bus   : fpu_issue_wb_if.slave (decode handshake, FPU drive/return,
//           register-file and SR write strobes, busy)
//
// Parameters:
//   LAT           : cycles from issue to the cycle fpuValD carries the result
//   REG_NONE      : destination/source code meaning "no register"
//   UCMD_FPU_NONE : opcode driven to the FPU when nothing issues
//
// Timing: an op issued in cycle N has its result sampled in N+LAT and its
// wbEn/srWrEn strobe high only in N+LAT+1. A dependent op sees dcReady low
// in N+1..N+LAT+1 and can issue at N+LAT+2 at the earliest.
module fpu_issue_wb #(
  parameter int         LAT           = 5,
  parameter logic [6:0] REG_NONE      = 7'h7F,
  parameter logic [7:0] UCMD_FPU_NONE = 8'h00
) (
  input logic          clock,
  input logic          reset,
  fpu_issue_wb_if.slave bus
);

  // One shadow-pipeline entry: the destination that the op will write.
  typedef struct packed {
    logic       valid;
    logic [6:0] rg;
    logic [1:0] mode;
    logic       wr_sr;
  } tag_t;

  tag_t [LAT-1:0] slot_q;
  tag_t [LAT-1:0] slot_d;

  logic        wb_en_q,    wb_en_d;
  logic [6:0]  wb_reg_q,   wb_reg_d;
  logic [1:0]  wb_mode_q,  wb_mode_d;
  logic [63:0] wb_val_q,   wb_val_d;
  logic        wb_hi_en_q, wb_hi_en_d;
  logic        sr_wr_en_q, sr_wr_en_d;
  logic        sr_t_q,     sr_t_d;

  logic hazard;
  logic dc_ready;
  logic issue;
  logic busy;
  tag_t tail;

  // Register overlap between a source and a destination. A double (mode 1)
  // on either side names an even/odd pair, so only bits [6:1] matter then.
  // REG_NONE on either side never overlaps anything.
  function automatic logic regs_overlap(input logic [6:0] src,
                                        input logic       src_dbl,
                                        input logic [6:0] dst,
                                        input logic       dst_dbl);
    logic hit;
    hit = 1'b0;
    if ((src != REG_NONE) && (dst != REG_NONE)) begin
      if (src_dbl || dst_dbl) begin
        hit = (src[6:1] == dst[6:1]);
      end else begin
        hit = (src == dst);
      end
    end
    return hit;
  endfunction

  // True if any of the three decode sources overlaps the given destination.
  function automatic logic srcs_hit(input logic [6:0] dst,
                                    input logic       dst_dbl,
                                    input logic [6:0] ra,
                                    input logic [6:0] rb,
                                    input logic [6:0] rc,
                                    input logic       src_dbl);
    return regs_overlap(ra, src_dbl, dst, dst_dbl) ||
           regs_overlap(rb, src_dbl, dst, dst_dbl) ||
           regs_overlap(rc, src_dbl, dst, dst_dbl);
  endfunction

  // Hazard: every in-flight destination plus the writeback that has not yet
  // reached the register file (it lands at the end of the wbEn cycle).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (slot_q[i].valid &&
          srcs_hit(slot_q[i].rg, (slot_q[i].mode == 2'd1),
                   bus.dcRegA, bus.dcRegB, bus.dcRegC, (bus.dcIdMode == 2'd1))) begin
        hazard = 1'b1;
      end
    end
    if (wb_en_q &&
        srcs_hit(wb_reg_q, (wb_mode_q == 2'd1),
                 bus.dcRegA, bus.dcRegB, bus.dcRegC, (bus.dcIdMode == 2'd1))) begin
      hazard = 1'b1;
    end
    if (!bus.dcValid) begin
      hazard = 1'b0;
    end
  end

  assign dc_ready = !hazard && !reset;
  assign issue    = bus.dcValid && dc_ready && !bus.flush;

  // FPU drive is combinational so the FPU sees the op in the issue cycle.
  always_comb begin
    bus.fpuOpMode = UCMD_FPU_NONE;
    bus.fpuIdMode = 2'd0;
    bus.fpuRegA   = REG_NONE;
    bus.fpuRegB   = REG_NONE;
    bus.fpuRegC   = REG_NONE;
    if (issue) begin
      bus.fpuOpMode = bus.dcOpMode;
      bus.fpuIdMode = bus.dcIdMode;
      bus.fpuRegA   = bus.dcRegA;
      bus.fpuRegB   = bus.dcRegB;
      bus.fpuRegC   = bus.dcRegC;
    end
  end

  // Shadow pipeline: shifts every cycle regardless of decode stalls, since
  // the FPU datapath itself never stalls. Ops with nothing to write (no
  // register, no SR update) are dropped at entry so they never hazard.
  always_comb begin
    slot_d          = '0;
    slot_d[0].valid = issue && ((bus.fpuIdRegD != REG_NONE) || bus.dcWrSr);
    slot_d[0].rg    = bus.fpuIdRegD;
    slot_d[0].mode  = bus.fpuIdModeD;
    slot_d[0].wr_sr = bus.dcWrSr;
    for (int i = 1; i < LAT; i++) begin
      slot_d[i] = slot_q[i-1];
    end
    if (bus.flush) begin
      for (int i = 0; i < LAT; i++) begin
        slot_d[i].valid = 1'b0;
      end
    end
  end

  assign tail = slot_q[LAT-1];

  // Writeback capture. Strobes are single-cycle; data fields hold their last
  // captured value between writebacks and across a flush.
  always_comb begin
    wb_en_d    = 1'b0;
    wb_hi_en_d = 1'b0;
    sr_wr_en_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_mode_d  = wb_mode_q;
    wb_val_d   = wb_val_q;
    sr_t_d     = sr_t_q;
    if (tail.valid && !bus.flush) begin
      wb_en_d    = (tail.rg != REG_NONE);
      wb_reg_d   = tail.rg;
      wb_mode_d  = tail.mode;
      wb_val_d   = bus.fpuValD;
      wb_hi_en_d = (tail.mode != 2'd0);
      sr_wr_en_d = tail.wr_sr;
      sr_t_d     = bus.fpuOutSr[0];
    end
  end

  always_comb begin
    busy = wb_en_q || sr_wr_en_q;
    for (int i = 0; i < LAT; i++) begin
      busy = busy || slot_q[i].valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= '0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= 7'd0;
      wb_mode_q  <= 2'd0;
      wb_val_q   <= 64'd0;
      wb_hi_en_q <= 1'b0;
      sr_wr_en_q <= 1'b0;
      sr_t_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      wb_mode_q  <= wb_mode_d;
      wb_val_q   <= wb_val_d;
      wb_hi_en_q <= wb_hi_en_d;
      sr_wr_en_q <= sr_wr_en_d;
      sr_t_q     <= sr_t_d;
    end
  end

  assign bus.dcReady = dc_ready;
  assign bus.wbEn    = wb_en_q;
  assign bus.wbReg   = wb_reg_q;
  assign bus.wbMode  = wb_mode_q;
  assign bus.wbVal   = wb_val_q;
  assign bus.wbHiEn  = wb_hi_en_q;
  assign bus.srWrEn  = sr_wr_en_q;
  assign bus.srT     = sr_t_q;
  assign bus.busy    = busy;

endmodule
